multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Sequencing controller for the next-generation multicycle core: it replaces the single-cycle control path with a state machine that fetches, decodes and executes one ARM-subset instruction over several cycles, sharing one memory port for instruction and data. It holds the architectural NZCV flags and checks conditions. It drives all datapath enables and mux selects, handshakes with a variable-latency memory, and counts retired instructions. It sits between the instruction register/ALU and the register file, PC register and memory.

## Interface
- `COUNT_WIDTH`, default 32: width of the retired-instruction counter.
- `clk` in 1: clock, rising edge.
- `reset_ni` in 1: asynchronous, active-low reset.
- `instr_i` in 32: instruction register contents, valid from DECODE onward.
- `alu_nzcv_i` in 4: ALU flags for the current ALU operation.
- `mem_ready_i` in 1: memory completes the current request this cycle.
- `ir_write_o` out 1: load the instruction register from memory read data.
- `pc_write_o` out 1: load PC from `pc_src_o`.
- `pc_src_o` out 1: 0 = PC+4, 1 = ALU result.
- `mem_req_o` out 1: memory request valid.
- `mem_we_o` out 1: request is a write.
- `mem_addr_src_o` out 1: 0 = PC, 1 = ALU result register.
- `alu_op_o` out 4: ALU control.
- `alu_b_src_o` out 1: 0 = shifter, 1 = immediate path.
- `reg_write_o` out 1: register file write enable, port 1.
- `reg_wd_src_o` out 2: 0 = ALU, 1 = memory data, 2 = PC+4 (link).
- `flags_o` out 4: architectural NZCV.
- `illegal_o` out 1: one-cycle pulse on an undefined instruction.
- `instret_o` out COUNT_WIDTH: retired-instruction count.

## Operation
- Instruction class `instr_i[27:26]`:
  - 00 = data-processing (DP); I bit is [25], opcode [24:21], S bit [20].
  - 01 = LDR/STR; L bit is [20], U bit is [23]. Offset addressing only, no writeback.
  - 10 = B/BL; link bit is [24].
  - 11 = undefined.
- Condition field `instr_i[31:28]` follows the standard ARM encoding, checked against `flags_o` in DECODE. 1111 is treated as never.
- States:
  - FETCH: `mem_req_o`=1, `mem_addr_src_o`=0. Holds until `mem_ready_i`. On ready, pulse `ir_write_o` and `pc_write_o` (`pc_src_o`=0), then go to DECODE.
  - DECODE: condition fails → FETCH, instruction counted as retired. Class 11 → pulse `illegal_o`, go to FETCH, not counted. Otherwise go to EXEC_DP, MEM_ADDR or BRANCH.
  - EXEC_DP: `alu_op_o`=opcode, `alu_b_src_o`=I. If S=1, latch `alu_nzcv_i` into flags at the end of the cycle. Opcodes 1000–1011 (TST/TEQ/CMP/CMN) → FETCH and retire. Otherwise → DP_WB.
  - DP_WB: `reg_write_o`=1, `reg_wd_src_o`=0. If Rd ([15:12]) = 15, drive `pc_write_o`=1 with `pc_src_o`=1 instead of a register write. Retire, go to FETCH.
  - MEM_ADDR: `alu_op_o` = ADD (0100) when U=1, SUB (0010) when U=0; `alu_b_src_o`=1. Then → MEM_RD if L=1, else MEM_WR.
  - MEM_RD / MEM_WR: `mem_req_o`=1, `mem_addr_src_o`=1, `mem_we_o` = (state==MEM_WR). Held until `mem_ready_i`. MEM_WR → FETCH and retire; MEM_RD → LD_WB.
  - LD_WB: `reg_write_o`=1, `reg_wd_src_o`=1. Retire, go to FETCH.
  - BRANCH: `alu_op_o`=ADD, `pc_write_o`=1, `pc_src_o`=1. If link=1, also `reg_write_o`=1 with `reg_wd_src_o`=2. Retire, go to FETCH.
- Outputs not listed for a state are 0.
- `instret_o` increments by 1 on each retire and wraps modulo 2^COUNT_WIDTH.

## Timing
- Reset: asynchronous entry to FETCH. Flags = 0000, `instret_o`=0, all other outputs 0.
  - After reset deasserts, the first rising edge is spent in FETCH, so `mem_req_o` is 1 from that edge.
  - Reset during a pending memory request drops `mem_req_o` immediately; the request is abandoned.
- Minimum latency at zero memory wait (ready in the same cycle as the request):
  - DP with writeback: 4 cycles.
  - Compare: 3 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Branch: 3 cycles.
  - Condition-failed: 2 cycles.
- Each memory wait cycle adds one cycle in FETCH, MEM_RD or MEM_WR.
- Memory handshake: `mem_req_o`, `mem_we_o` and `mem_addr_src_o` stay stable while waiting. A transfer completes on the edge where `mem_req_o` and `mem_ready_i` are both 1. `mem_ready_i` with no request is ignored.
- The flag update and the state change in EXEC_DP occur on the same edge. The next instruction's DECODE sees the updated flags.
- All outputs are Moore outputs (decoded from state and `instr_i`), except the handshake-completion pulses (`ir_write_o` and FETCH `pc_write_o`), which are gated by `mem_ready_i`.

## Structure
- Package `core_pkg`:
  - `state_t` enum.
  - `instr_class_t`.
  - `cond_t` (EQ..AL, NV).
  - `wd_src_t`.
  - ALU opcode constants (ADD, SUB, TST, TEQ, CMP, CMN).
- Sub-module `cond_check`: combinational; inputs cond[3:0] and nzcv[3:0], output pass. Shared with future pipelined cores.

## Test plan
- Reset, then `instr_i`=0xE2811005 (ADD r1,r1,#5), ready tied to 1:
  - FETCH→DECODE→EXEC_DP→DP_WB.
  - `reg_write_o` high in cycle 4 only.
  - `instret_o`=1.
- CMP r0,#0 with S and `alu_nzcv_i`=0100, then 0x0A000002 (BEQ):
  - flags become 0100.
  - Branch takes 3 cycles with `pc_write_o`/`pc_src_o`=1.
  - With flags 0000 instead, the BEQ retires in 2 cycles and no PC write beyond fetch.
- LDR 0xE5910004 with `mem_ready_i` low for 3 cycles in MEM_RD:
  - `mem_req_o`, `mem_addr_src_o`=1 and `mem_we_o`=0 held stable for 4 cycles.
  - LD_WB selects `reg_wd_src_o`=1.
  - 8 cycles total.
- BL 0xEB000010:
  - BRANCH asserts `reg_write_o` with `reg_wd_src_o`=2 and `pc_write_o` together.
- Undefined 0xEC000000:
  - `illegal_o` pulses one cycle in DECODE.
  - `instret_o` unchanged; next state is FETCH.
- `reset_ni` dropped mid MEM_WR wait:
  - `mem_req_o` falls without a clock edge; flags=0 and `instret_o`=0.
  - COUNT_WIDTH=4 run of 17 retires gives `instret_o`=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the multicycle core control path.
package core_pkg;

    // Controller sequencing states.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_DP  = 4'd2,
        S_DP_WB    = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_LD_WB    = 4'd7,
        S_BRANCH   = 4'd8
    } state_t;

    // Instruction class from bits [27:26].
    typedef enum logic [1:0] {
        CLS_DP     = 2'b00,
        CLS_MEM    = 2'b01,
        CLS_BRANCH = 2'b10,
        CLS_UNDEF  = 2'b11
    } instr_class_t;

    // ARM condition field encoding; NV (1111) is treated as never.
    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_t;

    // Register file write-data source select.
    typedef enum logic [1:0] {
        WD_ALU  = 2'd0,
        WD_MEM  = 2'd1,
        WD_LINK = 2'd2
    } wd_src_t;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_TST = 4'b1000;
    localparam logic [3:0] ALU_TEQ = 4'b1001;
    localparam logic [3:0] ALU_CMP = 4'b1010;
    localparam logic [3:0] ALU_CMN = 4'b1011;

    // Compare-class opcodes only set flags and never write a register.
    function automatic logic is_compare(input logic [3:0] op);
        return (op == ALU_TST) || (op == ALU_TEQ) ||
               (op == ALU_CMP) || (op == ALU_CMN);
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator; nzcv = {N, Z, C, V}.
module cond_check
    import core_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic  n, z, c, v;
    cond_t cond_e;

    assign {n, z, c, v} = nzcv;
    assign cond_e       = cond_t'(cond);

    // Evaluate the condition against the flags.
    always_comb begin
        pass = 1'b0;
        case (cond_e)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle fetch/decode/execute controller with shared memory port,
// NZCV flag register and retired-instruction counter.
// Memory handshake: mem_req_o/mem_we_o/mem_addr_src_o are held stable while
// waiting; a transfer completes on the edge where mem_req_o and mem_ready_i
// are both 1; mem_ready_i without a request is ignored.
module multicycle_controller
    import core_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_ni,
    input  logic [31:0]            instr_i,
    input  logic [3:0]             alu_nzcv_i,
    input  logic                   mem_ready_i,
    output logic                   ir_write_o,
    output logic                   pc_write_o,
    output logic                   pc_src_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic                   mem_addr_src_o,
    output logic [3:0]             alu_op_o,
    output logic                   alu_b_src_o,
    output logic                   reg_write_o,
    output logic [1:0]             reg_wd_src_o,
    output logic [3:0]             flags_o,
    output logic                   illegal_o,
    output logic [COUNT_WIDTH-1:0] instret_o
);

    state_t                 state_q, state_d;
    logic [3:0]             flags_q;
    logic [COUNT_WIDTH-1:0] instret_q;
    logic                   retire;
    logic                   flags_load;
    logic                   cond_pass;

    instr_class_t           cls;
    logic [3:0]             opcode;
    logic                   i_bit, s_bit, u_bit, l_bit, link_bit;
    logic                   rd_is_pc;
    logic                   unused_instr_bits;

    assign cls      = instr_class_t'(instr_i[27:26]);
    assign i_bit    = instr_i[25];
    assign opcode   = instr_i[24:21];
    assign s_bit    = instr_i[20];
    assign u_bit    = instr_i[23];
    assign l_bit    = instr_i[20];
    assign link_bit = instr_i[24];
    assign rd_is_pc = (instr_i[15:12] == 4'hF);

    assign unused_instr_bits = ^{instr_i[19:16], instr_i[11:0]};

    cond_check u_cond_check (
        .cond (instr_i[31:28]),
        .nzcv (flags_q),
        .pass (cond_pass)
    );

    // State register; reset lands in FETCH asynchronously.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) state_q <= S_FETCH;
        else           state_q <= state_d;
    end

    // Next-state and Moore output decode; FETCH request is masked during reset.
    always_comb begin
        state_d        = state_q;
        ir_write_o     = 1'b0;
        pc_write_o     = 1'b0;
        pc_src_o       = 1'b0;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_src_o = 1'b0;
        alu_op_o       = 4'b0000;
        alu_b_src_o    = 1'b0;
        reg_write_o    = 1'b0;
        reg_wd_src_o   = WD_ALU;
        illegal_o      = 1'b0;
        retire         = 1'b0;
        flags_load     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_o = reset_ni;
                if (reset_ni && mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!cond_pass) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    case (cls)
                        CLS_DP:     state_d = S_EXEC_DP;
                        CLS_MEM:    state_d = S_MEM_ADDR;
                        CLS_BRANCH: state_d = S_BRANCH;
                        default: begin
                            illegal_o = 1'b1;
                            state_d   = S_FETCH;
                        end
                    endcase
                end
            end
            S_EXEC_DP: begin
                alu_op_o    = opcode;
                alu_b_src_o = i_bit;
                flags_load  = s_bit;
                if (is_compare(opcode)) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_DP_WB;
                end
            end
            S_DP_WB: begin
                if (rd_is_pc) begin
                    pc_write_o = 1'b1;
                    pc_src_o   = 1'b1;
                end else begin
                    reg_write_o = 1'b1;
                end
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_op_o    = u_bit ? ALU_ADD : ALU_SUB;
                alu_b_src_o = 1'b1;
                state_d     = l_bit ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req_o      = 1'b1;
                mem_addr_src_o = 1'b1;
                if (mem_ready_i) state_d = S_LD_WB;
            end
            S_MEM_WR: begin
                mem_req_o      = 1'b1;
                mem_addr_src_o = 1'b1;
                mem_we_o       = 1'b1;
                if (mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_LD_WB: begin
                reg_write_o  = 1'b1;
                reg_wd_src_o = WD_MEM;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                alu_op_o   = ALU_ADD;
                pc_write_o = 1'b1;
                pc_src_o   = 1'b1;
                if (link_bit) begin
                    reg_write_o  = 1'b1;
                    reg_wd_src_o = WD_LINK;
                end
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Architectural flags and retired-instruction counter.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            flags_q   <= 4'b0000;
            instret_q <= '0;
        end else begin
            if (flags_load) flags_q <= alu_nzcv_i;
            if (retire)     instret_q <= instret_q + COUNT_WIDTH'(1);
        end
    end

    assign flags_o   = flags_q;
    assign instret_o = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed vector bench for multicycle_controller.
module tb_multicycle_controller;

    logic        clk;
    logic        reset_ni;
    logic [31:0] instr_i;
    logic [3:0]  alu_nzcv_i;
    logic        mem_ready_i;

    logic        ir_write_o, pc_write_o, pc_src_o, mem_req_o, mem_we_o;
    logic        mem_addr_src_o, alu_b_src_o, reg_write_o, illegal_o;
    logic [3:0]  alu_op_o, flags_o;
    logic [1:0]  reg_wd_src_o;
    logic [31:0] instret_o;

    logic        d4_ir_write, d4_pc_write, d4_pc_src, d4_mem_req, d4_mem_we;
    logic        d4_mem_addr_src, d4_alu_b_src, d4_reg_write, d4_illegal;
    logic [3:0]  d4_alu_op, d4_flags;
    logic [1:0]  d4_reg_wd_src;
    logic [3:0]  d4_instret;

    multicycle_controller dut (
        .clk(clk), .reset_ni(reset_ni), .instr_i(instr_i),
        .alu_nzcv_i(alu_nzcv_i), .mem_ready_i(mem_ready_i),
        .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_src_o(mem_addr_src_o), .alu_op_o(alu_op_o),
        .alu_b_src_o(alu_b_src_o), .reg_write_o(reg_write_o),
        .reg_wd_src_o(reg_wd_src_o), .flags_o(flags_o),
        .illegal_o(illegal_o), .instret_o(instret_o)
    );

    multicycle_controller #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .reset_ni(reset_ni), .instr_i(instr_i),
        .alu_nzcv_i(alu_nzcv_i), .mem_ready_i(mem_ready_i),
        .ir_write_o(d4_ir_write), .pc_write_o(d4_pc_write), .pc_src_o(d4_pc_src),
        .mem_req_o(d4_mem_req), .mem_we_o(d4_mem_we),
        .mem_addr_src_o(d4_mem_addr_src), .alu_op_o(d4_alu_op),
        .alu_b_src_o(d4_alu_b_src), .reg_write_o(d4_reg_write),
        .reg_wd_src_o(d4_reg_wd_src), .flags_o(d4_flags),
        .illegal_o(d4_illegal), .instret_o(d4_instret)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] exp_instret = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] instr;
        logic [3:0]  nzcv;
        int          fw;       // fetch wait cycles
        int          dw;       // data wait cycles
        int          cyc;      // expected total cycles
        int          ret;      // expected retire increment
        logic [3:0]  flags;    // expected flags afterwards
        int          regw;     // reg_write cycles
        int          regw_cyc; // cycle index of reg_write
        logic [1:0]  wd;       // write-data select at reg_write
        int          pcw;      // pc_write outside fetch
        int          ill;      // illegal pulses
        int          dcyc;     // data-phase request cycles
        logic        we;       // mem_we during data phase
        logic [3:0]  alu3;     // alu_op in cycle 3
        logic        bsrc3;    // alu_b_src in cycle 3
    } vec_t;

    vec_t vecs[16];

    // ---------------- driver / monitor for one instruction ----------------
    task automatic run_one(input vec_t v, input string tag);
        int cyc = 0, fw_cnt = 0, dw_cnt = 0;
        int regw = 0, regw_cyc = 0, pcw = 0, pcsrc_bad = 0, ill = 0;
        int dcyc = 0, irw = 0, we_unstable = 0;
        logic [1:0] wd = 0;
        logic [3:0] alu3 = 0;
        logic bsrc3 = 0, we_seen = 0, fetched = 0, is_fetch, is_data;
        instr_i    = v.instr;
        alu_nzcv_i = v.nzcv;
        while (1) begin
            is_fetch = mem_req_o && !mem_addr_src_o;
            is_data  = mem_req_o && mem_addr_src_o;
            if (is_fetch && fetched) break;
            if (cyc >= 40) begin
                check({tag, " timeout"}, 1, 0);
                break;
            end
            if (is_fetch) begin
                mem_ready_i = (fw_cnt >= v.fw);
                fw_cnt++;
            end else if (is_data) begin
                mem_ready_i = (dw_cnt >= v.dw);
                dw_cnt++;
                if (dcyc == 0) we_seen = mem_we_o;
                else if (mem_we_o !== we_seen) we_unstable++;
                dcyc++;
            end else begin
                mem_ready_i = 1'($urandom_range(0, 1));
            end
            #1;
            cyc++;
            if (ir_write_o) begin
                irw++;
                fetched = 1'b1;
            end
            if (cyc == 3) begin
                alu3  = alu_op_o;
                bsrc3 = alu_b_src_o;
            end
            if (reg_write_o) begin
                regw++;
                regw_cyc = cyc;
                wd = reg_wd_src_o;
            end
            if (pc_write_o && !is_fetch) begin
                pcw++;
                if (!pc_src_o) pcsrc_bad++;
            end
            if (pc_write_o && is_fetch && pc_src_o) pcsrc_bad++;
            if (illegal_o) ill++;
            @(negedge clk);
        end
        exp_instret = exp_instret + 32'(v.ret);
        check({tag, " cycles"},    cyc,        v.cyc);
        check({tag, " instret"},   instret_o,  exp_instret);
        check({tag, " instret4"},  d4_instret, exp_instret[3:0]);
        check({tag, " flags"},     flags_o,    v.flags);
        check({tag, " ir_write"},  irw,        1);
        check({tag, " reg_write"}, regw,       v.regw);
        check({tag, " regw_cyc"},  regw_cyc,   v.regw_cyc);
        if (v.regw > 0) check({tag, " wd_src"}, wd, v.wd);
        check({tag, " pc_write"},  pcw,        v.pcw);
        check({tag, " pc_src"},    pcsrc_bad,  0);
        check({tag, " illegal"},   ill,        v.ill);
        check({tag, " data_cyc"},  dcyc,       v.dcyc);
        if (v.dcyc > 0) begin
            check({tag, " mem_we"},     we_seen,     v.we);
            check({tag, " we_stable"},  we_unstable, 0);
        end
        check({tag, " alu_op3"},   alu3,       v.alu3);
        check({tag, " b_src3"},    bsrc3,      v.bsrc3);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        //            instr         nzcv  fw dw cyc ret flags  regw rc wd  pcw ill dcyc we alu3    b3
        vecs[0]  = '{32'hE2811005, 4'hF, 0, 0, 4, 1, 4'h0, 1, 4, 2'd0, 0, 0, 0, 0, 4'b0100, 1}; // ADD r1,#5
        vecs[1]  = '{32'hE3500000, 4'h4, 0, 0, 3, 1, 4'h4, 0, 0, 2'd0, 0, 0, 0, 0, 4'b1010, 1}; // CMP r0,#0
        vecs[2]  = '{32'h0A000002, 4'h0, 0, 0, 3, 1, 4'h4, 0, 0, 2'd0, 1, 0, 0, 0, 4'b0100, 0}; // BEQ taken
        vecs[3]  = '{32'hE3500000, 4'h0, 0, 0, 3, 1, 4'h0, 0, 0, 2'd0, 0, 0, 0, 0, 4'b1010, 1}; // CMP -> 0000
        vecs[4]  = '{32'h0A000002, 4'h0, 0, 0, 2, 1, 4'h0, 0, 0, 2'd0, 0, 0, 0, 0, 4'b0000, 0}; // BEQ not taken
        vecs[5]  = '{32'hE5910004, 4'h0, 0, 3, 8, 1, 4'h0, 1, 8, 2'd1, 0, 0, 4, 0, 4'b0100, 1}; // LDR, 3 waits
        vecs[6]  = '{32'hE5010008, 4'h0, 0, 0, 4, 1, 4'h0, 0, 0, 2'd0, 0, 0, 1, 1, 4'b0010, 1}; // STR U=0
        vecs[7]  = '{32'hE5810000, 4'h0, 0, 2, 6, 1, 4'h0, 0, 0, 2'd0, 0, 0, 3, 1, 4'b0100, 1}; // STR, 2 waits
        vecs[8]  = '{32'hEB000010, 4'h0, 0, 0, 3, 1, 4'h0, 1, 3, 2'd2, 1, 0, 0, 0, 4'b0100, 0}; // BL
        vecs[9]  = '{32'hEC000000, 4'h0, 0, 0, 2, 0, 4'h0, 0, 0, 2'd0, 0, 1, 0, 0, 4'b0000, 0}; // undefined
        vecs[10] = '{32'hE1A0F000, 4'h0, 0, 0, 4, 1, 4'h0, 0, 0, 2'd0, 1, 0, 0, 0, 4'b1101, 0}; // MOV pc,r0
        vecs[11] = '{32'hF2811005, 4'h0, 0, 0, 2, 1, 4'h0, 0, 0, 2'd0, 0, 0, 0, 0, 4'b0000, 0}; // NV never
        vecs[12] = '{32'hE2511001, 4'h9, 0, 0, 4, 1, 4'h9, 1, 4, 2'd0, 0, 0, 0, 0, 4'b0010, 1}; // SUBS
        vecs[13] = '{32'hBA000000, 4'h0, 0, 0, 2, 1, 4'h9, 0, 0, 2'd0, 0, 0, 0, 0, 4'b0000, 0}; // BLT fails
        vecs[14] = '{32'hAA000000, 4'h0, 0, 0, 3, 1, 4'h9, 0, 0, 2'd0, 1, 0, 0, 0, 4'b0100, 0}; // BGE taken
        vecs[15] = '{32'hE2811005, 4'h0, 2, 0, 6, 1, 4'h9, 1, 6, 2'd0, 0, 0, 0, 0, 4'b0000, 0}; // ADD, fetch waits

        // Reset: outputs idle even with ready asserted.
        reset_ni    = 1'b0;
        instr_i     = 32'h0;
        alu_nzcv_i  = 4'h0;
        mem_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        check("rst mem_req",   mem_req_o,   0);
        check("rst ir_write",  ir_write_o,  0);
        check("rst pc_write",  pc_write_o,  0);
        check("rst reg_write", reg_write_o, 0);
        check("rst flags",     flags_o,     0);
        check("rst instret",   instret_o,   0);

        reset_ni    = 1'b1;
        mem_ready_i = 1'b0;
        @(negedge clk);
        check("post-rst mem_req",  mem_req_o,      1);
        check("post-rst addr_src", mem_addr_src_o, 0);
        check("post-rst ir_write", ir_write_o,     0);

        for (int i = 0; i < 16; i++) run_one(vecs[i], $sformatf("v%0d", i));

        // Reset while a store waits on memory.
        instr_i    = 32'hE5810000;
        alu_nzcv_i = 4'h0;
        begin
            int k = 0;
            while (!(mem_req_o && mem_addr_src_o) && k < 10) begin
                mem_ready_i = 1'b1;
                @(negedge clk);
                k++;
            end
            check("mid-rst reach MEM_WR", k < 10, 1);
        end
        mem_ready_i = 1'b0;
        @(negedge clk);
        check("mid-rst waiting we", mem_we_o, 1);
        #2 reset_ni = 1'b0;
        #1;
        check("mid-rst mem_req",  mem_req_o,  0);
        check("mid-rst flags",    flags_o,    0);
        check("mid-rst instret",  instret_o,  0);
        check("mid-rst instret4", d4_instret, 0);
        @(negedge clk);
        reset_ni    = 1'b1;
        exp_instret = 0;
        @(negedge clk);

        // 17 retires: the 4-bit counter wraps to 1.
        for (int i = 0; i < 17; i++) begin
            vec_t a;
            a = '{32'hE2811005, 4'h0, 0, 0, 4, 1, 4'h0, 1, 4, 2'd0, 0, 0, 0, 0, 4'b0100, 1};
            run_one(a, $sformatf("wrap%0d", i));
        end
        check("wrap instret32", instret_o,  17);
        check("wrap instret4",  d4_instret, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
